uart_rx_word_module: RTL and testbench
======================================

Name: uart_rx_word_module

Overview:
- Receive-side counterpart of the board's multi-byte UART transmitter: consumes the serial stream produced by the TX stage (over the loopback/debug line) and reassembles it into a 64-bit word plus byte count.
- Frame format matches the TX stage:
  - 1 start bit (0), 8 data bits LSB-first, 2 stop bits (1).
  - Bytes are sent most-significant first.
- Output is consumed by the MIPS I/O register block.

Parameters:
- CLK_FREQ, 50000000, system clock in Hz.
- BAUD, 9600, line bit rate; DIV = CLK_FREQ/BAUD clocks per bit (integer division, DIV >= 4 required).
- IDLE_BITS, 20, bit-times of line idle that terminate a partial word.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_pin_in  input  1  asynchronous serial line, idle high.
- rx_len  input  4  expected bytes per word; 1..8 used as-is, 0 or >8 treated as 8; sampled when the first byte of a word completes.
- rx_data  output  64  assembled word; low rx_cnt bytes valid, upper bytes zero.
- rx_cnt  output  4  number of valid bytes in rx_data (1..8).
- rx_done  output  1  one-cycle pulse; rx_data/rx_cnt valid and held until next rx_done.
- frame_err  output  1  one-cycle pulse on bad stop bit.

Behaviour:
- Reset values:
  - Outputs: rx_data=0, rx_cnt=0, rx_done=0, frame_err=0.
  - Synchronizer flops=1, FSM=IDLE, bit counter=0, byte counter=0, shift word=0, idle counter=0.
- Input sync: 2-flop synchronizer; all logic below uses synchronized rx_s.
- FSM IDLE:
  - On rx_s==0, go to START and load the baud counter with DIV/2-1.
- FSM START:
  - When the counter hits 0, sample rx_s.
  - If 0: go to DATA, bit idx=0, counter=DIV-1.
  - If 1: false start, return to IDLE with no output.
- FSM DATA:
  - On each counter expiry, shift rx_s into bit position idx of the byte register (LSB-first) and reload DIV-1.
  - After idx 7, go to STOP.
- FSM STOP:
  - Sample the first stop bit at counter expiry.
  - If 1: byte accepted.
    - word <= {word[55:0], byte}.
    - byte_cnt <= byte_cnt+1.
    - On byte_cnt==0, latch target = effective rx_len.
  - If 0: pulse frame_err, discard the byte (word and byte_cnt unchanged).
  - Return to IDLE in both cases; the second stop bit is not checked, which allows back-to-back frames.
- Word completion (in the same cycle the accepting stop sample is taken, if byte_cnt+1 == target):
  - rx_data <= new word, rx_cnt <= byte_cnt+1, rx_done pulse next cycle.
  - Internal word and byte_cnt clear to 0.
- Idle timeout:
  - In IDLE with byte_cnt>0, the idle counter increments each clock.
  - The counter is cleared on any falling start detection or byte acceptance.
  - On reaching IDLE_BITS*DIV, flush: rx_data <= word, rx_cnt <= byte_cnt, rx_done pulse, clear word/byte_cnt.
  - No flush when byte_cnt==0.
- Latency: rx_done asserts 1 clock after the first-stop-bit sample point, i.e. roughly 9.5 bit-times + 3 clocks after the start edge of the last byte.
- frame_err and rx_done never both pulse for the same byte. A frame error on the last expected byte leaves the partial word pending; it completes via timeout.
- rx_len changes mid-word have no effect until the next word.
- rst mid-frame: immediate return to reset state; partial word lost, no pulses.
- Line held low (break): one frame_err after 9.5 bit-times. FSM then waits in IDLE (no new START) until rx_s has been seen high at least once.

Test Plan (CLK_FREQ=1600, BAUD=100 -> DIV=16, IDLE_BITS=20):
- Single byte: rx_len=1, send 0xA5 -> one rx_done, rx_data=0x00000000000000A5, rx_cnt=1, frame_err never set.
- Full word, MS byte first: rx_len=8, send 01,23,45,67,89,AB,CD,EF back-to-back with 2 stop bits -> rx_data=0x0123456789ABCDEF, rx_cnt=8, exactly one rx_done.
- Timeout flush: rx_len=4, send 0x12,0x34 then idle -> rx_done exactly 320 clocks after the second byte's acceptance, rx_data=0x1234, rx_cnt=2.
- Glitch/false start: 4-clock low pulse on idle line -> FSM back to IDLE, no rx_done, no frame_err; a following 0x5A with rx_len=1 is received correctly.
- Framing error: rx_len=2, send 0x11, then 0x22 with stop bit 0, then 0x33 -> frame_err one pulse; rx_data=0x1133, rx_cnt=2.
- Reset mid-frame: assert rst during bit 4 of the second byte of a rx_len=2 word -> all outputs 0, no rx_done; next 2-byte word 0xBEEF received as rx_data=0xBEEF.

Source files
------------

// File: rtl/uart_rx_word_module.sv
// 8N2 LSB-first UART receiver that packs most-significant-first bytes into a 64-bit word.
// A word completes when the expected byte count arrives or after the line has been idle long enough.
module uart_rx_word_module #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 9600,
    parameter int IDLE_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_pin_in,
    input  logic [3:0]  rx_len,
    output logic [63:0] rx_data,
    output logic [3:0]  rx_cnt,
    output logic        rx_done,
    output logic        frame_err
);
    localparam int DIV        = CLK_FREQ / BAUD;
    localparam int IDLE_LIMIT = IDLE_BITS * DIV;
    localparam int BW         = $clog2(DIV) + 1;
    localparam int IW         = $clog2(IDLE_LIMIT) + 1;
    localparam logic [BW-1:0] BAUD_FULL = BW'(DIV - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(DIV / 2 - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_LIMIT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    function automatic logic [3:0] eff_len(input logic [3:0] len);
        if ((len == 4'd0) || (len > 4'd8)) begin
            return 4'd8;
        end else begin
            return len;
        end
    endfunction

    state_t        state_r, state_s;
    logic          rx_meta_r, rx_sync_r;
    logic          armed_r, armed_s;
    logic [BW-1:0] baud_cnt_r, baud_cnt_s;
    logic [2:0]    bit_idx_r, bit_idx_s;
    logic [7:0]    byte_r, byte_s;
    logic [63:0]   word_r, word_s;
    logic [3:0]    byte_cnt_r, byte_cnt_s;
    logic [3:0]    target_r, target_s;
    logic [3:0]    tgt_s;
    logic [IW-1:0] idle_cnt_r, idle_cnt_s;
    logic [63:0]   rx_data_r, rx_data_s;
    logic [3:0]    rx_cnt_r, rx_cnt_s;
    logic          rx_done_r, rx_done_s;
    logic          frame_err_r, frame_err_s;

    // Next-state and output decode for the receive FSM and word assembly
    always_comb begin
        state_s     = state_r;
        armed_s     = armed_r | rx_sync_r;
        baud_cnt_s  = baud_cnt_r;
        bit_idx_s   = bit_idx_r;
        byte_s      = byte_r;
        word_s      = word_r;
        byte_cnt_s  = byte_cnt_r;
        target_s    = target_r;
        idle_cnt_s  = idle_cnt_r;
        rx_data_s   = rx_data_r;
        rx_cnt_s    = rx_cnt_r;
        rx_done_s   = 1'b0;
        frame_err_s = 1'b0;
        tgt_s       = (byte_cnt_r == 4'd0) ? eff_len(rx_len) : target_r;
        case (state_r)
            ST_IDLE: begin
                // A start edge is honoured only once the line has been seen high after a frame error
                if (!rx_sync_r && armed_r) begin
                    state_s    = ST_START;
                    baud_cnt_s = BAUD_HALF;
                    idle_cnt_s = '0;
                end else if (byte_cnt_r != 4'd0) begin
                    if (idle_cnt_r == IDLE_LAST) begin
                        rx_data_s  = word_r;
                        rx_cnt_s   = byte_cnt_r;
                        rx_done_s  = 1'b1;
                        word_s     = 64'd0;
                        byte_cnt_s = 4'd0;
                        idle_cnt_s = '0;
                    end else begin
                        idle_cnt_s = idle_cnt_r + IW'(1);
                    end
                end else begin
                    idle_cnt_s = '0;
                end
            end
            ST_START: begin
                if (baud_cnt_r == '0) begin
                    if (!rx_sync_r) begin
                        state_s    = ST_DATA;
                        bit_idx_s  = 3'd0;
                        baud_cnt_s = BAUD_FULL;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r - BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_cnt_r == '0) begin
                    byte_s[bit_idx_r] = rx_sync_r;
                    baud_cnt_s        = BAUD_FULL;
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r - BW'(1);
                end
            end
            ST_STOP: begin
                if (baud_cnt_r == '0) begin
                    state_s = ST_IDLE;
                    if (rx_sync_r) begin
                        idle_cnt_s = '0;
                        target_s   = tgt_s;
                        if ((byte_cnt_r + 4'd1) == tgt_s) begin
                            rx_data_s  = {word_r[55:0], byte_r};
                            rx_cnt_s   = byte_cnt_r + 4'd1;
                            rx_done_s  = 1'b1;
                            word_s     = 64'd0;
                            byte_cnt_s = 4'd0;
                        end else begin
                            word_s     = {word_r[55:0], byte_r};
                            byte_cnt_s = byte_cnt_r + 4'd1;
                        end
                    end else begin
                        frame_err_s = 1'b1;
                        armed_s     = 1'b0;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r - BW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, synchronizer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r   <= 1'b1;
            rx_sync_r   <= 1'b1;
            state_r     <= ST_IDLE;
            armed_r     <= 1'b1;
            baud_cnt_r  <= '0;
            bit_idx_r   <= 3'd0;
            byte_r      <= 8'd0;
            word_r      <= 64'd0;
            byte_cnt_r  <= 4'd0;
            target_r    <= 4'd0;
            idle_cnt_r  <= '0;
            rx_data_r   <= 64'd0;
            rx_cnt_r    <= 4'd0;
            rx_done_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rx_meta_r   <= rx_pin_in;
            rx_sync_r   <= rx_meta_r;
            state_r     <= state_s;
            armed_r     <= armed_s;
            baud_cnt_r  <= baud_cnt_s;
            bit_idx_r   <= bit_idx_s;
            byte_r      <= byte_s;
            word_r      <= word_s;
            byte_cnt_r  <= byte_cnt_s;
            target_r    <= target_s;
            idle_cnt_r  <= idle_cnt_s;
            rx_data_r   <= rx_data_s;
            rx_cnt_r    <= rx_cnt_s;
            rx_done_r   <= rx_done_s;
            frame_err_r <= frame_err_s;
        end
    end

    assign rx_data   = rx_data_r;
    assign rx_cnt    = rx_cnt_r;
    assign rx_done   = rx_done_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_rx_word_module.sv
// Bench for uart_rx_word_module: table of word vectors, hand-written corner sequences,
// and random words checked against a byte-list reference model.
module tb_uart_rx_word_module;
    localparam int CLK_FREQ  = 1600;
    localparam int BAUD      = 100;
    localparam int IDLE_BITS = 20;
    localparam int DIV       = CLK_FREQ / BAUD;
    localparam int LAT       = DIV / 2 + 9 * DIV + 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_pin_in;
    logic [3:0]  rx_len;
    logic [63:0] rx_data;
    logic [3:0]  rx_cnt;
    logic        rx_done;
    logic        frame_err;

    uart_rx_word_module #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .IDLE_BITS(IDLE_BITS)) dut (
        .clk(clk), .rst(rst), .rx_pin_in(rx_pin_in), .rx_len(rx_len),
        .rx_data(rx_data), .rx_cnt(rx_cnt), .rx_done(rx_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] q_data[$];
    logic [3:0]  q_cnt[$];
    int          q_cyc[$];
    int          fe_total = 0;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rx_done) begin
            q_data.push_back(rx_data);
            q_cnt.push_back(rx_cnt);
            q_cyc.push_back(cyc);
        end
        if (frame_err) fe_total <= fe_total + 1;
    end

    int checks = 0;
    int failures = 0;
    int last_start = 0;

    typedef struct {
        logic [3:0]  len;
        int          n;
        logic [63:0] bytes;
        logic [63:0] exp_data;
        logic [3:0]  exp_cnt;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_pin_in = v;
        tick(DIV);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        last_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        drive_bit(1'b1);
    endtask

    task automatic expect_word(input string name, input int qb, input int fb,
                               input logic [63:0] ed, input logic [3:0] ec, input int efe);
        logic [63:0] ad;
        logic [3:0]  ac;
        ad = 'x;
        ac = 'x;
        if (q_data.size() > qb) begin
            ad = q_data[qb];
            ac = q_cnt[qb];
        end
        check({name, "_ndone"}, 64'(q_data.size() - qb), 64'd1);
        check({name, "_data"}, ad, ed);
        check({name, "_cnt"}, 64'(ac), 64'(ec));
        check({name, "_ferr"}, 64'(fe_total - fb), 64'(efe));
    endtask

    initial begin
        int qb, fb, idx;
        vecs[0] = '{4'd1,  1, 64'hA5,               64'hA5,               4'd1};
        vecs[1] = '{4'd8,  8, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 4'd8};
        vecs[2] = '{4'd4,  2, 64'h1234,             64'h1234,             4'd2};
        vecs[3] = '{4'd0,  8, 64'h1122334455667788, 64'h1122334455667788, 4'd8};
        vecs[4] = '{4'd12, 8, 64'hF0E1D2C3B4A59687, 64'hF0E1D2C3B4A59687, 4'd8};
        vecs[5] = '{4'd3,  3, 64'hC0FFEE,           64'hC0FFEE,           4'd3};
        vecs[6] = '{4'd2,  1, 64'h7F,               64'h7F,               4'd1};

        rst = 1'b1;
        rx_pin_in = 1'b1;
        rx_len = 4'd1;
        tick(3);
        check("reset_data", rx_data, 64'd0);
        check("reset_cnt", 64'(rx_cnt), 64'd0);
        check("reset_done", 64'(rx_done), 64'd0);
        check("reset_ferr", 64'(frame_err), 64'd0);
        rst = 1'b0;
        tick(20);

        for (int v = 0; v < 7; v++) begin
            qb = q_data.size();
            fb = fe_total;
            rx_len = vecs[v].len;
            for (int k = 0; k < vecs[v].n; k++) begin
                idx = 8 * (vecs[v].n - 1 - k);
                send_frame(vecs[v].bytes[idx +: 8], 1'b1);
            end
            tick(400);
            expect_word($sformatf("vec%0d", v), qb, fb, vecs[v].exp_data, vecs[v].exp_cnt, 0);
        end

        // Completion latency and exact timeout flush timing
        qb = q_data.size();
        rx_len = 4'd2;
        send_frame(8'hAB, 1'b1);
        send_frame(8'hCD, 1'b1);
        tick(50);
        check("latency_ndone", 64'(q_data.size() - qb), 64'd1);
        if (q_data.size() > qb) check("latency_cyc", 64'(q_cyc[qb] - last_start), 64'(LAT));
        else check("latency_cyc", 64'd0, 64'(LAT));
        qb = q_data.size();
        fb = fe_total;
        rx_len = 4'd4;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        tick(400);
        expect_word("timeout", qb, fb, 64'h1234, 4'd2, 0);
        if (q_cyc.size() > qb) check("timeout_cyc", 64'(q_cyc[qb] - last_start), 64'(LAT + IDLE_BITS * DIV));
        else check("timeout_cyc", 64'd0, 64'(LAT + IDLE_BITS * DIV));

        // Glitch on an idle line
        qb = q_data.size();
        fb = fe_total;
        rx_pin_in = 1'b0;
        tick(4);
        rx_pin_in = 1'b1;
        tick(40);
        check("glitch_ndone", 64'(q_data.size() - qb), 64'd0);
        check("glitch_ferr", 64'(fe_total - fb), 64'd0);
        rx_len = 4'd1;
        send_frame(8'h5A, 1'b1);
        tick(50);
        expect_word("glitch_next", qb, fb, 64'h5A, 4'd1, 0);

        // Framing error on the middle byte
        qb = q_data.size();
        fb = fe_total;
        rx_len = 4'd2;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b0);
        send_frame(8'h33, 1'b1);
        tick(50);
        expect_word("frame_err", qb, fb, 64'h1133, 4'd2, 1);

        // rx_len change mid-word is ignored until the next word
        qb = q_data.size();
        fb = fe_total;
        rx_len = 4'd2;
        send_frame(8'h01, 1'b1);
        rx_len = 4'd1;
        send_frame(8'h02, 1'b1);
        tick(400);
        expect_word("len_change", qb, fb, 64'h0102, 4'd2, 0);

        // Reset during bit 4 of the second byte
        rx_len = 4'd2;
        send_frame(8'h12, 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0 ^ (8'h34 >> i) & 1'b1);
        rx_pin_in = 1'b1;
        tick(DIV / 2);
        rst = 1'b1;
        tick(1);
        check("rst_data", rx_data, 64'd0);
        check("rst_cnt", 64'(rx_cnt), 64'd0);
        check("rst_done", 64'(rx_done), 64'd0);
        check("rst_ferr", 64'(frame_err), 64'd0);
        tick(1);
        rst = 1'b0;
        qb = q_data.size();
        fb = fe_total;
        tick(500);
        check("rst_nolost_done", 64'(q_data.size() - qb), 64'd0);
        check("rst_noferr", 64'(fe_total - fb), 64'd0);
        send_frame(8'hBE, 1'b1);
        send_frame(8'hEF, 1'b1);
        tick(50);
        expect_word("rst_next", qb, fb, 64'hBEEF, 4'd2, 0);

        // Break: line held low produces one frame error, then nothing until it goes high
        qb = q_data.size();
        fb = fe_total;
        rx_pin_in = 1'b0;
        tick(30 * DIV);
        rx_pin_in = 1'b1;
        tick(100);
        check("break_ferr", 64'(fe_total - fb), 64'd1);
        check("break_ndone", 64'(q_data.size() - qb), 64'd0);
        fb = fe_total;
        rx_len = 4'd1;
        send_frame(8'h3C, 1'b1);
        tick(50);
        expect_word("break_next", qb, fb, 64'h3C, 4'd1, 0);

        // Random words against a byte-list model
        for (int it = 0; it < 20; it++) begin
            logic [3:0]  len;
            logic [7:0]  b;
            logic [63:0] exp;
            int          eff, n, nbad;
            len = 4'($urandom_range(0, 15));
            eff = (len == 4'd0 || len > 4'd8) ? 8 : int'(len);
            n = $urandom_range(1, eff);
            rx_len = len;
            exp = 64'd0;
            nbad = 0;
            qb = q_data.size();
            fb = fe_total;
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 4) == 0) begin
                    send_frame(8'($urandom), 1'b0);
                    nbad++;
                end
                b = 8'($urandom);
                send_frame(b, 1'b1);
                exp = (exp << 8) | 64'(b);
                tick(DIV * $urandom_range(0, 2));
            end
            tick(400);
            expect_word($sformatf("rand%0d", it), qb, fb, exp, 4'(n), nbad);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
